// File: rtl/any1_pkg.sv
// Shared types, opcode classes and sequencer states for the ANY1 memory path.
// Opcode class lives in ir[6:2]; ir[1:0] carries the access size.
package any1_pkg;

   typedef logic [31:0] Instruction;
   typedef logic [31:0] Address;

   localparam logic [4:0] OPC_LDX   = 5'h10;
   localparam logic [4:0] OPC_LDXX  = 5'h11;
   localparam logic [4:0] OPC_STX   = 5'h12;
   localparam logic [4:0] OPC_STXX  = 5'h13;
   localparam logic [4:0] OPC_LDSX  = 5'h14;
   localparam logic [4:0] OPC_STSX  = 5'h15;
   localparam logic [4:0] OPC_LDXVX = 5'h16;
   localparam logic [4:0] OPC_STXVX = 5'h17;

   typedef enum logic [2:0] {
      VM_IDLE,
      VM_GEN,
      VM_ADR,
      VM_REQ,
      VM_FIN
   } any1_vmseq_state_t;

   function automatic logic is_scl(input Instruction i);
      return i[6:2] inside {OPC_LDX, OPC_LDXX,
                            OPC_STX, OPC_STXX};
   endfunction

   function automatic logic is_vec(input Instruction i);
      return i[6:2] inside {OPC_LDSX, OPC_STSX,
                            OPC_LDXVX, OPC_STXVX};
   endfunction

   function automatic logic is_st(input Instruction i);
      return i[6:2] inside {OPC_STX, OPC_STXX,
                            OPC_STSX, OPC_STXVX};
   endfunction

endpackage

// File: rtl/any1_vmem_seq_if.sv
// Issue / address-generator / dcache request bundle of the vector memory
// sequencer; master is the sequencer side.
interface any1_vmem_seq_if;
   import any1_pkg::*;

   logic        start;
   logic        abort;
   Instruction  ir;
   logic [6:0]  vl;
   logic [63:0] mask;
   Address      ea;
   Instruction  ir_o;
   logic [5:0]  step;
   logic        busy;
   logic        mreq;
   logic        mwr;
   Address      mea;
   logic        mack;
   logic [6:0]  cnt;
   logic        done;

   modport master (
      input  start, abort, ir, vl, mask, ea, mack,
      output ir_o, step, busy, mreq, mwr, mea, cnt, done
   );

   modport slave (
      output start, abort, ir, vl, mask, ea, mack,
      input  ir_o, step, busy, mreq, mwr, mea, cnt, done
   );

endinterface

// File: rtl/any1_ffo64.sv
// Lowest set bit of vec with pos <= index < lim; found=0 when none.
module any1_ffo64 (
   input  logic [63:0] vec,
   input  logic [6:0]  pos,
   input  logic [6:0]  lim,
   output logic [5:0]  idx,
   output logic        found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 63; i >= 0; i--) begin
         if (vec[i] && (7'(i) >= pos) && (7'(i) < lim)) begin
            idx   = 6'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/any1_vmem_seq.sv
// Element sequencer for multi-element memory ops; one handshaken request
// per active element. ANY1_VMEM_MASK_EN enables the element mask.
module any1_vmem_seq
   import any1_pkg::*;
#(
   parameter int NEL = 64
) (
   input  logic clk,
   input  logic rst,
   any1_vmem_seq_if.master bus
);

   any1_vmseq_state_t state_q, state_d;
   Instruction        ir_q, ir_d;
   logic [6:0]        vl_q, vl_d;
   logic [NEL-1:0]    mask_q, mask_d;
   logic [5:0]        step_q, step_d;
   logic [6:0]        cnt_q, cnt_d;
   Address            mea_q, mea_d;
   logic              mreq_q, mreq_d;
   logic              mwr_q, mwr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [63:0] in_mask;
   logic [63:0] ff_vec;
   logic [6:0]  ff_pos;
   logic [6:0]  ff_lim;
   logic [5:0]  ff_idx;
   logic        ff_found;

   always_comb begin
`ifdef ANY1_VMEM_MASK_EN
      in_mask = bus.mask;
`else
      in_mask = '1;
`endif
   end

   // One search unit: first active element at start, next one afterwards
   always_comb begin
      if (state_q == VM_IDLE) begin
         ff_vec = in_mask;
         ff_pos = '0;
         ff_lim = bus.vl;
      end else begin
         ff_vec = mask_q;
         ff_pos = {1'b0, step_q} + 7'd1;
         ff_lim = vl_q;
      end
   end

   any1_ffo64 u_ffo (
      .vec   (ff_vec),
      .pos   (ff_pos),
      .lim   (ff_lim),
      .idx   (ff_idx),
      .found (ff_found)
   );

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      vl_d    = vl_q;
      mask_d  = mask_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      mea_d   = mea_q;
      mreq_d  = mreq_q;
      mwr_d   = mwr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         VM_IDLE: begin
            if (bus.start) begin
               ir_d   = bus.ir;
               vl_d   = bus.vl;
               mask_d = in_mask;
               cnt_d  = '0;
               busy_d = 1'b1;
               mwr_d  = is_st(bus.ir);
               step_d = ff_idx;
               // Scalar ops look like a one-element vector
               if (is_scl(bus.ir)) begin
                  vl_d    = 7'd1;
                  mask_d  = NEL'(1);
                  step_d  = '0;
                  state_d = VM_GEN;
               end else if (is_vec(bus.ir) && ff_found) begin
                  state_d = VM_GEN;
               end else begin
                  state_d = VM_FIN;
                  done_d  = 1'b1;
               end
            end
         end
         VM_GEN: state_d = VM_ADR;
         VM_ADR: begin
            mea_d   = bus.ea;
            mreq_d  = 1'b1;
            state_d = VM_REQ;
         end
         VM_REQ: begin
            if (bus.mack) begin
               cnt_d  = cnt_q + 7'd1;
               mreq_d = 1'b0;
               if (ff_found) begin
                  step_d  = ff_idx;
                  state_d = VM_GEN;
               end else begin
                  state_d = VM_FIN;
                  done_d  = 1'b1;
               end
            end
         end
         VM_FIN: begin
            busy_d  = 1'b0;
            state_d = VM_IDLE;
         end
         default: state_d = VM_IDLE;
      endcase
      // Abort drops everything in flight but keeps the partial count
      if (bus.abort) begin
         state_d = VM_IDLE;
         ir_d    = ir_q;
         vl_d    = vl_q;
         mask_d  = mask_q;
         step_d  = step_q;
         cnt_d   = cnt_q;
         mea_d   = mea_q;
         mwr_d   = mwr_q;
         mreq_d  = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= VM_IDLE;
         ir_q    <= '0;
         vl_q    <= '0;
         mask_q  <= '0;
         step_q  <= '0;
         cnt_q   <= '0;
         mea_q   <= '0;
         mreq_q  <= 1'b0;
         mwr_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         vl_q    <= vl_d;
         mask_q  <= mask_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         mea_q   <= mea_d;
         mreq_q  <= mreq_d;
         mwr_q   <= mwr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.ir_o = ir_q;
   assign bus.step = step_q;
   assign bus.busy = busy_q;
   assign bus.mreq = mreq_q;
   assign bus.mwr  = mwr_q;
   assign bus.mea  = mea_q;
   assign bus.cnt  = cnt_q;
   assign bus.done = done_q;

endmodule
